// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader_if
//  Description : FIFO read port plus valid/ready output stream seen by the
//                FIFO stream reader. master = reader side, slave = FIFO/sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_pop;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_pop,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_pop,
        input  m_valid,
        input  m_data
    );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Pops a synchronous FIFO and streams the words out over
//                valid/ready through a 2-entry skid buffer (1 word/clk).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               en,
    fifo_stream_reader_if.master    bus,
    output logic [COUNT_W-1:0]      xfer_count,
    output logic                    idle
);

    logic [1:0]         r_occ;
    logic               r_inflight;
    logic               r_valid;
    logic [WIDTH-1:0]   r_buf0;
    logic [WIDTH-1:0]   r_buf1;
    logic [COUNT_W-1:0] r_count;

    logic               w_deq;
    logic               w_pop;
    logic [2:0]         w_level;
    logic [1:0]         w_tail;
    logic [1:0]         w_occ_next;
    logic [WIDTH-1:0]   w_buf0_next;
    logic [WIDTH-1:0]   w_buf1_next;

    assign w_deq   = r_valid & bus.m_ready;

    // Words that will be held after this edge if no further pop is issued;
    // a pop is only allowed while that leaves room for the returning word.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign w_pop   = en & ~bus.fifo_empty & ~rst & (w_level < 3'd2);

    // Slot the captured word lands in, after the head has been retired.
    assign w_tail  = r_occ - {1'b0, w_deq};

    always_comb begin
        w_buf0_next = r_buf0;
        w_buf1_next = r_buf1;
        w_occ_next  = r_occ + {1'b0, r_inflight} - {1'b0, w_deq};
        if (w_deq) begin
            w_buf0_next = r_buf1;
        end
        if (r_inflight) begin
            if (w_tail == 2'd0) begin
                w_buf0_next = bus.fifo_rdata;
            end else begin
                w_buf1_next = bus.fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_count    <= '0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= w_pop;
            r_valid    <= (w_occ_next != 2'd0);
            r_buf0     <= w_buf0_next;
            r_buf1     <= w_buf1_next;
            if (w_deq) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.fifo_pop = w_pop;
    assign bus.m_valid  = r_valid;
    assign bus.m_data   = r_buf0;
    assign xfer_count   = r_count;
    assign idle         = (r_occ == 2'd0) & ~r_inflight;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        ({1'b0, r_occ} + {2'b00, r_inflight}) <= 3'd2);

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Bench for fifo_stream_reader: behavioural FIFO, scoreboard
//                queue and an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int c_WIDTH   = 8;
    localparam int c_COUNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en  = 1'b0;
    logic [c_COUNT_W-1:0] xfer_count;
    logic                 idle;

    fifo_stream_reader_if #(.WIDTH(c_WIDTH)) bus ();

    fifo_stream_reader #(.WIDTH(c_WIDTH), .COUNT_W(c_COUNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus),
        .xfer_count (xfer_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    logic [c_WIDTH-1:0] fifo_q[$];
    logic [c_WIDTH-1:0] exp_q[$];
    int total = 0, bad = 0;
    int cyc = 0;
    int n_pop = 0, n_deliv = 0, n_dropped = 0;
    int first_pop = -1, last_pop = -1, first_deliv = -1, last_deliv = -1;
    logic               prev_hold = 1'b0;
    logic [c_WIDTH-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [c_WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // Words popped but never delivered are lost by a reset.
    task automatic discard_lost();
        int lost;
        lost = n_pop - n_deliv - n_dropped;
        for (int i = 0; i < lost; i++) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_dropped += lost;
    endtask

    task automatic wait_deliv(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (n_deliv < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(n_deliv >= target), 32'd1);
    endtask

    // Behavioural FIFO with a registered read port and registered empty flag.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        bus.m_ready    = 1'b0;
    end

    always @(posedge clk) begin
        if (bus.fifo_pop) begin
            chk("pop_not_empty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) bus.fifo_rdata <= fifo_q.pop_front();
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
        cyc++;
    end

    // Output monitor: sampled mid-cycle, a handshake seen here completes at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(bus.m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
                end
                n_deliv++;
                if (first_deliv < 0) first_deliv = cyc;
                last_deliv = cyc;
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
        end
    end

    initial begin
        int p0, d0;

        // Reset behaviour with data available and en high.
        en = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(i));
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pop", 32'(bus.fifo_pop), 32'd0);
            chk("rst_valid", 32'(bus.m_valid), 32'd0);
            chk("rst_count", 32'(xfer_count), 32'd0);
            chk("rst_idle", 32'(idle), 32'd1);
        end

        // Full-throughput streaming of 00..03.
        first_pop = -1; first_deliv = -1;
        rst = 1'b0;
        wait_deliv("t2_timeout", 4, 30);
        chk("t2_pops", 32'(n_pop), 32'd4);
        chk("t2_pop_span", 32'(last_pop - first_pop), 32'd3);
        chk("t2_latency", 32'(first_deliv - first_pop), 32'd2);
        chk("t2_deliv_span", 32'(last_deliv - first_deliv), 32'd3);
        chk("t2_count", 32'(xfer_count), 32'd4);
        chk("t2_idle", 32'(idle), 32'd1);

        // Back-pressure: only two pops, head word held.
        bus.m_ready = 1'b0;
        p0 = n_pop; d0 = n_deliv;
        for (int i = 0; i < 4; i++) push(8'(i));
        repeat (8) tick();
        chk("t3_pops", 32'(n_pop - p0), 32'd2);
        chk("t3_valid", 32'(bus.m_valid), 32'd1);
        chk("t3_head", 32'(bus.m_data), 32'h00);
        bus.m_ready = 1'b1;
        wait_deliv("t3_timeout", d0 + 4, 30);
        chk("t3_pops_all", 32'(n_pop - p0), 32'd4);
        chk("t3_count", 32'(xfer_count), 32'd8);

        // en dropped the cycle after the second pop.
        en = 1'b0;
        p0 = n_pop; d0 = n_deliv;
        for (int i = 0; i < 4; i++) push(8'(i));
        tick();
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        repeat (8) tick();
        chk("t4_pops", 32'(n_pop - p0), 32'd2);
        chk("t4_deliv", 32'(n_deliv - d0), 32'd2);
        chk("t4_idle", 32'(idle), 32'd1);
        chk("t4_fifo_left", 32'(fifo_q.size()), 32'd2);
        if (fifo_q.size() == 2) begin
            chk("t4_fifo_w0", 32'(fifo_q[0]), 32'h02);
            chk("t4_fifo_w1", 32'(fifo_q[1]), 32'h03);
        end

        // Counter wrap: 17 words after a reset with a 4-bit counter.
        rst = 1'b1;
        discard_lost();
        tick();
        rst = 1'b0;
        chk("t5_count_rst", 32'(xfer_count), 32'd0);
        d0 = n_deliv;
        for (int i = 0; i < 15; i++) push(8'(8'h10 + i));
        en = 1'b1;
        bus.m_ready = 1'b1;
        wait_deliv("t5_timeout", d0 + 17, 60);
        chk("t5_wrap", 32'(xfer_count), 32'd1);

        // 200 words under random back-pressure.
        for (int i = 0; i < 200; i++) push(8'(i * 7 + 3));
        begin
            int k;
            k = 0;
            while (n_deliv < d0 + 217 && k < 3000) begin
                bus.m_ready = 1'($urandom_range(0, 1));
                tick();
                k++;
            end
        end
        bus.m_ready = 1'b1;
        chk("t5_rand_done", 32'(n_deliv - d0), 32'd217);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_count_217", 32'(xfer_count), 32'd9);
        tick();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
        repeat (4) tick();
        #1;
        rst = 1'b1;
        #1;
        chk("t6_valid_async", 32'(bus.m_valid), 32'd0);
        chk("t6_pop_async", 32'(bus.fifo_pop), 32'd0);
        chk("t6_idle_async", 32'(idle), 32'd1);
        discard_lost();
        tick();
        rst = 1'b0;
        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 60) begin
                tick();
                k++;
            end
        end
        tick();
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_fifo_empty", 32'(fifo_q.size()), 32'd0);
        chk("t6_idle_end", 32'(idle), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
